inst_rom_arbiter: RTL and testbench

INST_ROM_ARBITER -- requirements
Module: inst_rom_arbiter

---
 rtl/inst_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_arbiter.sv
// Single-ported instruction ROM shared by the fetch and constant-load ports, one-cycle read latency.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fetch priority with a load starvation override.
module inst_rom_arbiter #(
    parameter int ROM_WORDS  = 131071,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    output logic        ls_stall,
    output logic        ls_valid,
    output logic [31:0] ls_data,
    output logic        ls_err,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst
);

    logic        grant_if;
    logic        grant_ls;
    logic        ls_bad;
    logic        if_valid_q;
    logic        ls_valid_q;
    logic        ls_err_q;
    logic [31:0] if_inst_q;
    logic [31:0] ls_data_q;

    assign ls_bad = (ls_addr[1:0] != 2'b00) || ({2'b00, ls_addr[31:2]} >= 32'(ROM_WORDS));

`ifdef ROM_ARB_RR_EN
    // Names the port that wins the next contended cycle; fetch goes first after reset.
    logic next_ls;

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!rst) begin
            if (if_req && ls_req) begin
                grant_ls = next_ls;
                grant_if = ~next_ls;
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_ls <= 1'b0;
        end else if (grant_if) begin
            next_ls <= 1'b1;
        end else if (grant_ls) begin
            next_ls <= 1'b0;
        end
    end
`else
    logic [2:0] starve_cnt;
    logic       starve_hit;

    assign starve_hit = (starve_cnt == 3'(STARVE_MAX));

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (!rst) begin
            if (if_req && ls_req) begin
                grant_ls = starve_hit;
                grant_if = ~starve_hit;
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (ls_req && !grant_ls) begin
            if (!starve_hit) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end else begin
            starve_cnt <= 3'd0;
        end
    end
`endif

    // A rejected load still takes its grant slot but never touches the ROM.
    assign rom_ce   = grant_if || (grant_ls && !ls_bad);
    assign rom_addr = grant_if ? if_addr : (grant_ls ? ls_addr : 32'd0);
    assign if_stall = if_req && !grant_if && !rst;
    assign ls_stall = ls_req && !grant_ls && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_err_q   <= 1'b0;
            if_inst_q  <= 32'd0;
            ls_data_q  <= 32'd0;
        end else begin
            if_valid_q <= grant_if;
            ls_valid_q <= grant_ls;
            ls_err_q   <= grant_ls && ls_bad;
            if (grant_if) begin
                if_inst_q <= rom_inst;
            end
            if (grant_ls) begin
                ls_data_q <= ls_bad ? 32'd0 : rom_inst;
            end
        end
    end

    // Reset masks the response registers immediately so an in-flight read never surfaces.
    assign if_valid = if_valid_q && !rst;
    assign ls_valid = ls_valid_q && !rst;
    assign ls_err   = ls_err_q && !rst;
    assign if_inst  = rst ? 32'd0 : if_inst_q;
    assign ls_data  = rst ? 32'd0 : ls_data_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboard bench for inst_rom_arbiter: directed corner cases then randomized traffic.
module tb_inst_rom_arbiter;
    localparam int ROM_WORDS  = 131071;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = 32'd0;
    logic        if_stall, if_valid, ls_stall, ls_valid, ls_err, rom_ce;
    logic [31:0] if_inst, ls_data, rom_addr, rom_inst;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   starve = 0;
    int   last_port = 0;
    bit   if_pend = 1'b0;
    bit   ls_pend = 1'b0;
    exp_t if_q[$];
    exp_t ls_q[$];
    logic [31:0] last_if = 32'd0;
    logic [31:0] last_ls = 32'd0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h3401_1100;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic bit ls_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(ROM_WORDS));
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'hDEAD_BEEF;

    inst_rom_arbiter #(.ROM_WORDS(ROM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_valid(if_valid), .if_inst(if_inst),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_stall(ls_stall), .ls_valid(ls_valid), .ls_data(ls_data),
        .ls_err(ls_err), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive, check combinational grant outputs, record expected responses.
    task automatic cycle(input logic r, input logic ir, input logic [31:0] ia,
                         input logic lr, input logic [31:0] la);
        bit   gi, gl, ok;
        exp_t e;
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
        #1;
        cyc++;
        ok = ls_ok(la);
        gi = 1'b0;
        gl = 1'b0;
        if (!r) begin
            if (ir && lr) begin
`ifdef ROM_ARB_RR_EN
                gl = (last_port == 1);
`else
                gl = (starve == STARVE_MAX);
`endif
                gi = !gl;
            end else begin
                gi = ir;
                gl = lr;
            end
        end
        chk("if_stall", 32'(if_stall), 32'(ir && !gi && !r));
        chk("ls_stall", 32'(ls_stall), 32'(lr && !gl && !r));
        chk("rom_ce", 32'(rom_ce), 32'(gi || (gl && ok)));
        if (gi) chk("rom_addr_if", rom_addr, ia);
        else if (gl && ok) chk("rom_addr_ls", rom_addr, la);
        else if (!gl) chk("rom_addr_idle", rom_addr, 32'd0);
        if (r) begin
            if_q.delete();
            ls_q.delete();
            last_if = 32'd0;
            last_ls = 32'd0;
            starve = 0;
            last_port = 0;
            chk("rst_if_valid", 32'(if_valid), 32'd0);
            chk("rst_ls_valid", 32'(ls_valid), 32'd0);
            chk("rst_ls_err", 32'(ls_err), 32'd0);
            chk("rst_if_inst", if_inst, 32'd0);
            chk("rst_ls_data", ls_data, 32'd0);
        end else begin
            if (gi) begin
                e.data = rom_word(ia); e.err = 1'b0; e.cyc = cyc;
                if_q.push_back(e);
            end
            if (gl) begin
                e.data = ok ? rom_word(la) : 32'd0; e.err = !ok; e.cyc = cyc;
                ls_q.push_back(e);
            end
            if (gl || !lr) starve = 0;
            else if (starve < STARVE_MAX) starve++;
            if (gi) last_port = 1;
            else if (gl) last_port = 2;
        end
        if_pend = ir && !gi && !r;
        ls_pend = lr && !gl && !r;
    endtask

    function automatic logic [31:0] gen_ls_addr();
        case ($urandom % 8)
            0: return {15'd0, 15'($urandom % ROM_WORDS), 2'($urandom_range(1, 3))};
            1: return 32'(ROM_WORDS + $urandom % 16) << 2;
            2: return 32'(ROM_WORDS - 1) << 2;
            3: return $urandom;
            default: return 32'($urandom % ROM_WORDS) << 2;
        endcase
    endfunction

    task automatic rand_cycle();
        logic r, ir, lr;
        logic [31:0] ia, la;
        r = ($urandom % 64) == 0;
        if (if_pend && ($urandom % 8 != 0)) begin
            ir = 1'b1; ia = if_addr;
        end else begin
            ir = ($urandom % 4) != 0; ia = $urandom;
        end
        if (ls_pend && ($urandom % 8 != 0)) begin
            lr = 1'b1; la = ls_addr;
        end else begin
            lr = ($urandom % 3) != 0; la = gen_ls_addr();
        end
        cycle(r, ir, ia, lr, la);
    endtask

    // Monitor: pops the response recorded one cycle earlier whenever a port presents valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (if_valid) begin
                    if (if_q.size() > 0 && if_q[0].cyc == cyc - 1) begin
                        e = if_q.pop_front();
                        chk("if_data", if_inst, e.data);
                        last_if = e.data;
                    end else chk("if_unexpected_valid", 32'(if_valid), 32'd0);
                end else begin
                    if (if_q.size() > 0 && if_q[0].cyc == cyc - 1) begin
                        chk("if_missing_valid", 32'(if_valid), 32'd1);
                        void'(if_q.pop_front());
                    end
                    chk("if_hold", if_inst, last_if);
                end
                if (ls_valid) begin
                    if (ls_q.size() > 0 && ls_q[0].cyc == cyc - 1) begin
                        e = ls_q.pop_front();
                        chk("ls_data", ls_data, e.data);
                        chk("ls_err", 32'(ls_err), 32'(e.err));
                        last_ls = e.data;
                    end else chk("ls_unexpected_valid", 32'(ls_valid), 32'd0);
                end else begin
                    if (ls_q.size() > 0 && ls_q[0].cyc == cyc - 1) begin
                        chk("ls_missing_valid", 32'(ls_valid), 32'd1);
                        void'(ls_q.pop_front());
                    end
                    chk("ls_hold", ls_data, last_ls);
                    chk("ls_err_idle", 32'(ls_err), 32'd0);
                end
            end
        end
    end

    initial begin
        cycle(1, 1, 32'h10, 1, 32'h8);
        cycle(1, 1, 32'h10, 1, 32'h8);
        mon_en = 1'b1;
        cycle(1, 1, 32'h10, 1, 32'h8);
`ifdef ROM_ARB_RR_EN
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 1, 32'(k * 4), 1, 32'h8);
            chk("rr_if_stall", 32'(if_stall), 32'(k % 2 == 0));
            chk("rr_ls_stall", 32'(ls_stall), 32'(k % 2 == 1));
        end
        cycle(0, 0, 32'd0, 0, 32'd0);
`endif
        cycle(0, 1, 32'd0, 0, 32'd0);
        chk("first_rom_ce", 32'(rom_ce), 32'd1);
        chk("first_rom_addr", rom_addr, 32'd0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        chk("first_if_valid", 32'(if_valid), 32'd1);
        chk("first_if_inst", if_inst, 32'h3401_1100);
`ifndef ROM_ARB_RR_EN
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 1, 32'(256 + k * 4), 1, 32'h8);
            chk("starve_ls_stall", 32'(ls_stall), 32'(k <= 4));
            chk("starve_if_stall", 32'(if_stall), 32'(k == 5));
        end
        cycle(0, 1, 32'h300, 1, 32'h8);
        chk("starve_ls_valid", 32'(ls_valid), 32'd1);
        chk("starve_ls_data", ls_data, rom_word(32'h8));
        cycle(0, 1, 32'h304, 1, 32'h8);
        cycle(0, 1, 32'h308, 0, 32'h8);
        chk("drop_ls_stall", 32'(ls_stall), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 1, 32'(512 + k * 4), 1, 32'hC);
            if (k == 1) chk("drop_no_valid", 32'(ls_valid), 32'd0);
            chk("drop_ls_stall_again", 32'(ls_stall), 32'(k <= 4));
        end
        cycle(0, 0, 32'd0, 0, 32'd0);
`endif
        cycle(0, 0, 32'd0, 1, 32'h6);
        chk("misalign_rom_ce", 32'(rom_ce), 32'd0);
        chk("misalign_ls_stall", 32'(ls_stall), 32'd0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        chk("misalign_ls_valid", 32'(ls_valid), 32'd1);
        chk("misalign_ls_err", 32'(ls_err), 32'd1);
        chk("misalign_ls_data", ls_data, 32'd0);
        cycle(0, 1, 32'h40, 0, 32'd0);
        cycle(1, 0, 32'd0, 0, 32'd0);
        chk("rst_inflight_valid", 32'(if_valid), 32'd0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        chk("rst_after_valid", 32'(if_valid), 32'd0);
        chk("rst_after_inst", if_inst, 32'd0);
        repeat (4000) rand_cycle();
        cycle(0, 0, 32'd0, 0, 32'd0);
        cycle(0, 0, 32'd0, 0, 32'd0);
        chk("if_pending", 32'(if_q.size()), 32'd0);
        chk("ls_pending", 32'(ls_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
